cvp_mem_responder: RTL and testbench

Word-addressed memory responder for the CVP14 bus: the target end of the processor's Addr/RD/WR/dataOut/DataIn interface. It services the core's instruction fetches, VLD element reads and VST element writes from an on-chip array, with registered one-cycle read latency. It sits between the core and the test bench. It also reports protocol violations, the length of the last sequential burst, and a sticky copy of the core's overflow flag V.

---
 rtl/cvp_bus_pkg.sv | 7 +
 rtl/cvp_sram.sv | 23 ++
 rtl/cvp_mem_responder.sv | 101 ++++++++++
 tb/tb_cvp_mem_responder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cvp_bus_pkg.sv
// cvp_bus_pkg: shared state enum and defaults for the CVP14 memory responder
package cvp_bus_pkg;
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RBURST, ST_WBURST} resp_state_e;
  localparam int ADDR_W_DEF = 10;
  localparam logic [15:0] RD_POISON_DEF = 16'h0000;
  localparam int BURST_MAX = 31;
endpackage

// File: rtl/cvp_sram.sv
// cvp_sram: single-port sync RAM, 16-bit words; clk/rst, we/addr/wdata write port, re-gated registered rdata (rst clears rdata)
module cvp_sram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);
  logic [15:0] mem [2**ADDR_W];
  logic [15:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else if (re) rdata_q <= mem[addr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/cvp_mem_responder.sv
// cvp_mem_responder: CVP14 bus memory target; Clk1/Reset, Addr/RD/WR/WrData/V in; RdData/Ready/Err/OvfSticky/BurstLen out
module cvp_mem_responder
  import cvp_bus_pkg::*;
#(
  parameter int          ADDR_W    = ADDR_W_DEF,
  parameter logic [15:0] RD_POISON = RD_POISON_DEF
) (
  input  logic        Clk1,
  input  logic        Reset,
  input  logic [15:0] Addr,
  input  logic        RD,
  input  logic        WR,
  input  logic [15:0] WrData,
  input  logic        V,
  output logic [15:0] RdData,
  output logic        Ready,
  output logic        Err,
  output logic        OvfSticky,
  output logic [4:0]  BurstLen
);
  resp_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, ram_addr;
  logic [15:0]       prev_q, prev_d, ram_wdata, ram_rdata;
  logic [4:0]        run_q, run_d, len_q, len_d;
  logic              err_q, err_d, ovf_q, ovf_d, poison_q, poison_d;
  logic              init, in_range, acc, cont, rd_ok, wr_ok, ram_we;

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      prev_q   <= '0;
      run_q    <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      poison_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      run_q    <= run_d;
      len_q    <= len_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      poison_q <= poison_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    len_d   = len_q;
    prev_d  = prev_q;
    if (init) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = &cnt_q ? ST_IDLE : ST_INIT;
    end else if (acc && cont) begin
      run_d  = run_q == 5'(BURST_MAX) ? run_q : run_q + 5'd1;
      prev_d = Addr;
    end else begin
      len_d   = state_q == ST_IDLE ? len_q : run_q;
      state_d = !acc ? ST_IDLE : WR ? ST_WBURST : ST_RBURST;
      run_d   = acc ? 5'd1 : run_q;
      prev_d  = Addr;
    end
  end

  // A conflict cycle (RD and WR) tracks as a write; the read half is discarded.
  always_comb begin
    init      = state_q == ST_INIT;
    in_range  = (Addr >> ADDR_W) == 16'd0;
    acc       = RD | WR;
    cont      = (WR ? state_q == ST_WBURST : state_q == ST_RBURST) && Addr == prev_q + 16'd1;
    wr_ok     = !init && WR && in_range;
    rd_ok     = !init && RD && !WR;
    ram_we    = init | wr_ok;
    ram_addr  = init ? cnt_q : Addr[ADDR_W-1:0];
    ram_wdata = init ? 16'h0000 : WrData;
    err_d     = err_q | (acc && (init || !in_range || (RD && WR)));
    ovf_d     = ovf_q | V;
    poison_d  = rd_ok ? !in_range : poison_q;
  end

  cvp_sram #(.ADDR_W(ADDR_W)) u_sram (
    .clk   (Clk1),
    .rst   (Reset),
    .we    (ram_we),
    .re    (rd_ok && in_range),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign RdData    = poison_q ? RD_POISON : ram_rdata;
  assign Ready     = !init;
  assign Err       = err_q;
  assign OvfSticky = ovf_q;
  assign BurstLen  = len_q;
endmodule

// File: tb/tb_cvp_mem_responder.sv
// tb_cvp_mem_responder: directed and randomized checks of cvp_mem_responder against a behavioural model
module tb_cvp_mem_responder;
  logic        Clk1 = 1'b0, Reset = 1'b1, RD = 1'b0, WR = 1'b0, V = 1'b0;
  logic [15:0] Addr = '0, WrData = '0;
  logic [15:0] RdData;
  logic        Ready, Err, OvfSticky;
  logic [4:0]  BurstLen;
  int          total = 0, bad = 0;
  bit          chk_en = 1'b0;

  cvp_mem_responder dut (
    .Clk1      (Clk1),
    .Reset     (Reset),
    .Addr      (Addr),
    .RD        (RD),
    .WR        (WR),
    .WrData    (WrData),
    .V         (V),
    .RdData    (RdData),
    .Ready     (Ready),
    .Err       (Err),
    .OvfSticky (OvfSticky),
    .BurstLen  (BurstLen)
  );

  always #5 Clk1 = ~Clk1;

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  logic [15:0] m_mem [1024];
  logic [15:0] m_rd, m_last;
  int          m_left, m_len, m_kind, m_run, m_k;
  bit          m_err, m_ovf, m_inr;

  always @(posedge Clk1) begin
    if (Reset) begin
      foreach (m_mem[i]) m_mem[i] = 16'h0000;
      m_left = 1024; m_rd = 16'h0000; m_err = 0; m_ovf = 0;
      m_len = 0; m_kind = 0; m_run = 0; m_last = 16'h0000;
    end else begin
      m_ovf = m_ovf | V;
      if (m_left > 0) begin
        if (RD || WR) m_err = 1;
        m_left--;
      end else begin
        m_inr = Addr < 16'd1024;
        if (WR) begin
          if (m_inr) m_mem[Addr[9:0]] = WrData;
          if (RD || !m_inr) m_err = 1;
        end else if (RD) begin
          m_rd = m_inr ? m_mem[Addr[9:0]] : 16'h0000;
          if (!m_inr) m_err = 1;
        end
        m_k = WR ? 2 : RD ? 1 : 0;
        if (m_k != 0 && m_k == m_kind && Addr == m_last + 16'd1)
          m_run = m_run < 31 ? m_run + 1 : 31;
        else begin
          if (m_kind != 0) m_len = m_run;
          m_kind = m_k;
          m_run = 1;
        end
        m_last = Addr;
      end
    end
  end

  always @(negedge Clk1) begin
    if (chk_en) begin
      cmp("ready", Ready, m_left == 0);
      cmp("rddata", RdData, m_rd);
      cmp("err", Err, m_err);
      cmp("ovf", OvfSticky, m_ovf);
      cmp("burstlen", BurstLen, m_len);
    end
  end

  task automatic step(input bit rst, input bit rd, input bit wr, input logic [15:0] a,
                      input logic [15:0] d, input bit v);
    Reset = rst; RD = rd; WR = wr; Addr = a; WrData = d; V = v;
    @(negedge Clk1);
  endtask

  task automatic idle();
    step(0, 0, 0, 16'h0000, 16'h0000, 0);
  endtask

  task automatic wait_ready(input string name, input int expect_n);
    int n;
    n = 0;
    while (!Ready && n < 2000) begin
      idle();
      n++;
    end
    cmp(name, n, expect_n);
  endtask

  initial begin
    int r;
    logic [15:0] a, la;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk_en = 1;
    cmp("rst_ready", Ready, 0);
    cmp("rst_rddata", RdData, 0);
    cmp("rst_err", Err, 0);
    cmp("rst_ovf", OvfSticky, 0);
    cmp("rst_len", BurstLen, 0);
    wait_ready("init_cycles", 1024);
    step(0, 1, 0, 16'h03FF, 0, 0);
    cmp("init_clear_3ff", RdData, 16'h0000);
    step(0, 0, 1, 16'h0005, 16'h1234, 0);
    step(0, 1, 0, 16'h0005, 0, 0);
    cmp("fetch_data", RdData, 16'h1234);
    idle();
    cmp("fetch_hold", RdData, 16'h1234);
    cmp("fetch_err", Err, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 16'h0040 + 16'(i), 16'h0100 + 16'(i), 0);
    idle();
    cmp("wburst_len", BurstLen, 16);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 16'h0040 + 16'(i), 0, 0);
      cmp("rburst_data", RdData, 16'h0100 + 16'(i));
    end
    idle();
    cmp("rburst_len", BurstLen, 16);
    for (int i = 0; i < 40; i++) step(0, 0, 1, 16'h0100 + 16'(i), 16'(i), 0);
    idle();
    cmp("burst_sat", BurstLen, 31);
    step(0, 1, 0, 16'h0005, 0, 0);
    step(0, 1, 1, 16'h0010, 16'hBEEF, 0);
    cmp("conflict_rd_hold", RdData, 16'h1234);
    cmp("conflict_err", Err, 1);
    step(0, 1, 0, 16'h0010, 0, 0);
    cmp("conflict_wrote", RdData, 16'hBEEF);
    step(0, 1, 0, 16'h0400, 0, 0);
    cmp("oor_poison", RdData, 16'h0000);
    cmp("oor_err", Err, 1);
    step(0, 0, 1, 16'h0400, 16'hDEAD, 0);
    step(0, 1, 0, 16'h0000, 0, 0);
    cmp("oor_wr_dropped", RdData, 16'h0000);
    step(0, 0, 0, 0, 0, 1);
    cmp("ovf_set", OvfSticky, 1);
    idle();
    cmp("ovf_hold", OvfSticky, 1);
    step(0, 1, 0, 16'h0040, 0, 0);
    step(0, 1, 0, 16'h0041, 0, 0);
    step(0, 1, 0, 16'h0042, 0, 0);
    step(1, 1, 0, 16'h0043, 0, 0);
    cmp("mid_rst_ready", Ready, 0);
    cmp("mid_rst_err", Err, 0);
    cmp("mid_rst_ovf", OvfSticky, 0);
    cmp("mid_rst_len", BurstLen, 0);
    cmp("mid_rst_rddata", RdData, 0);
    step(0, 1, 0, 16'h0005, 0, 0);
    cmp("init_access_err", Err, 1);
    wait_ready("reinit_cycles", 1023);
    la = 16'h0000;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) step(1, 0, 0, 0, 0, 0);
      r = int'($urandom_range(99));
      a = ($urandom_range(3) != 0) ? la + 16'd1 : 16'($urandom_range(1100));
      if ($urandom_range(49) == 0) a = 16'hFFFF;
      step(0, r < 40, r >= 30 && r < 70, a, 16'($urandom), $urandom_range(199) == 0);
      la = a;
    end
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
